lsu_mem_arbiter: RTL and testbench
==================================

# lsu_mem_arbiter

Per-core arbiter between the per-thread load-store units and a single data-memory channel. Each LSU raises a read or write request and holds it until acknowledged. This block picks one request at a time by round-robin, forwards it to memory, and returns the response to the granted LSU. It sits directly downstream of the LSUs and upstream of the global data-memory controller.

## Interface
Parameters:
- NUM_CONSUMERS, 4: number of LSUs (threads per block) served.
- ADDR_BITS, 8: address width.
- DATA_BITS, 8: data width.

Ports (clock and reset first):
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- consumer_read_valid  input  [NUM_CONSUMERS]x1  LSU read request, held until ready seen.
- consumer_read_address  input  [NUM_CONSUMERS]xADDR_BITS  read address.
- consumer_read_ready  output  [NUM_CONSUMERS]x1  read acknowledge; read data valid while high.
- consumer_read_data  output  [NUM_CONSUMERS]xDATA_BITS  returned read data.
- consumer_write_valid  input  [NUM_CONSUMERS]x1  LSU write request.
- consumer_write_address  input  [NUM_CONSUMERS]xADDR_BITS  write address.
- consumer_write_data  input  [NUM_CONSUMERS]xDATA_BITS  write data.
- consumer_write_ready  output  [NUM_CONSUMERS]x1  write acknowledge.
- mem_read_valid / mem_read_address  output  1 / ADDR_BITS  memory read request.
- mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read response.
- mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  memory write request.
- mem_write_ready  input  1  memory write acknowledge.

## Operation
- State machine: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Registers: `current_consumer` (which LSU is granted) and `last_grant`.
- IDLE:
  - Scan consumers (last_grant+1) mod N, (last_grant+2) mod N, … up to N entries.
  - The first consumer with read_valid or write_valid wins; read has priority over write within that consumer.
  - Read winner: latch mem_read_address <= its address, mem_read_valid <= 1, go to READ_WAITING.
  - Write winner: latch mem_write_address and mem_write_data, mem_write_valid <= 1, go to WRITE_WAITING.
  - On either grant: current_consumer <= i, last_grant <= i.
  - No request: stay in IDLE.
- READ_WAITING: on mem_read_ready=1:
  - mem_read_valid <= 0.
  - consumer_read_data[cur] <= mem_read_data.
  - consumer_read_ready[cur] <= 1.
  - Go to READ_RELAYING.
- WRITE_WAITING: on mem_write_ready=1:
  - mem_write_valid <= 0.
  - consumer_write_ready[cur] <= 1.
  - Go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING (four-phase close):
  - When the granted consumer's valid for that operation is 0: its ready <= 0, go to IDLE.
  - Otherwise hold ready high.
- Requests from non-granted consumers are ignored (not lost); they are rescanned in the next IDLE.
- mem_*_ready is sampled only in the matching WAITING state; any other assertion is ignored.
- consumer_read_data[i] holds its last value until that consumer's next read completes.
- Addresses and data are captured at grant; later changes on consumer inputs are ignored until the next grant.

## Timing
- Reset values:
  - All ready outputs 0; mem_read_valid and mem_write_valid 0.
  - All addresses and data outputs 0.
  - State IDLE; last_grant = NUM_CONSUMERS-1, so the first scan starts at consumer 0.
- Reset mid-transaction: all of the above apply on the next edge. The in-flight memory request is dropped (valid falls). No ready is issued to the consumer.
- Grant latency: request sampled at edge E gives mem_*_valid high after E (1 cycle).
- Response latency: mem ready sampled at edge R gives consumer ready high and mem valid low after R.
- Release: consumer valid low sampled at edge F gives consumer ready low and IDLE after F. The next grant is possible at edge F+1.
- Minimum transaction with a zero-wait memory is 4 cycles: grant, response, release, next IDLE.
- At most one consumer ready and at most one mem valid are high in any cycle.

## Test plan
- Single read: consumer 2 reads address 0x15, memory returns 0xA7 two cycles later.
  -> mem_read_address=0x15, consumer_read_data[2]=0xA7, consumer_read_ready[2] high until valid drops.
- Single write: consumer 1 writes 0x3C to address 0x40.
  -> mem_write_address=0x40, mem_write_data=0x3C, consumer_write_ready[1] pulses after mem_write_ready, then clears.
- Contention: all 4 consumers issue reads simultaneously right after reset.
  -> grant order 0,1,2,3.
  -> Consumer 0 re-requesting after its completion is granted only after 3 (wrap-around).
- Mixed: consumer 3 writes while consumer 0 reads, last_grant=2.
  -> consumer 3 write is served first, then the consumer 0 read.
- Slow memory: mem_read_ready held low for 10 cycles.
  -> mem_read_valid and address stay stable; no consumer ready during the wait.
- Reset mid-operation: assert reset in READ_WAITING.
  -> next cycle mem_read_valid=0, all ready=0, state IDLE.
  -> After release, the pending request is granted starting from consumer 0.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
// Bundle between the per-thread LSUs, the LSU arbiter and the data-memory channel.
// The arbiter connects through the master modport; the environment connects through slave.
interface lsu_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  // Four-phase handshake on every channel: the requester raises valid (with stable
  // address/data) and holds it until it sees ready; the responder holds ready high
  // until the requester drops valid, and only then drops ready.
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  logic [2:0]           dbg_state;
  logic [CW-1:0]        dbg_current_consumer;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    output dbg_state, dbg_current_consumer
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    input  dbg_state, dbg_current_consumer
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter: grants one LSU read/write at a time onto the single
// data-memory channel and relays the response back to the granted LSU.
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input logic                clk,
  input logic                reset,
  lsu_mem_arbiter_if.master  bus
);
  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    READ_WAITING   = 3'd1,
    WRITE_WAITING  = 3'd2,
    READ_RELAYING  = 3'd3,
    WRITE_RELAYING = 3'd4
  } state_e;

  state_e                                  state_q, state_d;
  logic [CW-1:0]                           current_consumer_q, current_consumer_d;
  logic [CW-1:0]                           last_grant_q, last_grant_d;
  logic                                    mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]                    mem_read_address_q, mem_read_address_d;
  logic                                    mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]                    mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]                    mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]                read_ready_q, read_ready_d;
  logic [NUM_CONSUMERS-1:0]                write_ready_q, write_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q, read_data_d;

  logic          grant_found;
  logic          grant_is_read;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] scan_idx;

  // Scan starts one past the last grant so every LSU is reached within N grants.
  always_comb begin
    grant_found   = 1'b0;
    grant_is_read = 1'b0;
    grant_idx     = '0;
    scan_idx      = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      scan_idx = CW'((int'(last_grant_q) + k) % NUM_CONSUMERS);
      if (!grant_found &&
          (bus.consumer_read_valid[scan_idx] || bus.consumer_write_valid[scan_idx])) begin
        grant_found   = 1'b1;
        grant_idx     = scan_idx;
        grant_is_read = bus.consumer_read_valid[scan_idx];
      end
    end
  end

  always_comb begin
    state_d             = state_q;
    current_consumer_d  = current_consumer_q;
    last_grant_d        = last_grant_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    read_ready_d        = read_ready_q;
    write_ready_d       = write_ready_q;
    read_data_d         = read_data_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          current_consumer_d = grant_idx;
          last_grant_d       = grant_idx;
          if (grant_is_read) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = bus.consumer_read_address[grant_idx];
            state_d            = READ_WAITING;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = bus.consumer_write_address[grant_idx];
            mem_write_data_d    = bus.consumer_write_data[grant_idx];
            state_d             = WRITE_WAITING;
          end
        end
      end
      READ_WAITING: begin
        if (bus.mem_read_ready) begin
          mem_read_valid_d                = 1'b0;
          read_data_d[current_consumer_q]  = bus.mem_read_data;
          read_ready_d[current_consumer_q] = 1'b1;
          state_d                         = READ_RELAYING;
        end
      end
      WRITE_WAITING: begin
        if (bus.mem_write_ready) begin
          mem_write_valid_d                 = 1'b0;
          write_ready_d[current_consumer_q] = 1'b1;
          state_d                           = WRITE_RELAYING;
        end
      end
      READ_RELAYING: begin
        if (!bus.consumer_read_valid[current_consumer_q]) begin
          read_ready_d[current_consumer_q] = 1'b0;
          state_d                          = IDLE;
        end
      end
      WRITE_RELAYING: begin
        if (!bus.consumer_write_valid[current_consumer_q]) begin
          write_ready_d[current_consumer_q] = 1'b0;
          state_d                           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= IDLE;
      current_consumer_q  <= '0;
      last_grant_q        <= CW'(NUM_CONSUMERS - 1);
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      read_ready_q        <= '0;
      write_ready_q       <= '0;
      read_data_q         <= '0;
    end else begin
      state_q             <= state_d;
      current_consumer_q  <= current_consumer_d;
      last_grant_q        <= last_grant_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      read_ready_q        <= read_ready_d;
      write_ready_q       <= write_ready_d;
      read_data_q         <= read_data_d;
    end
  end

  assign bus.consumer_read_ready  = read_ready_q;
  assign bus.consumer_read_data   = read_data_q;
  assign bus.consumer_write_ready = write_ready_q;
  assign bus.mem_read_valid       = mem_read_valid_q;
  assign bus.mem_read_address     = mem_read_address_q;
  assign bus.mem_write_valid      = mem_write_valid_q;
  assign bus.mem_write_address    = mem_write_address_q;
  assign bus.mem_write_data       = mem_write_data_q;
  assign bus.dbg_state            = state_q;
  assign bus.dbg_current_consumer = current_consumer_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();
  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard: consumer ids in the order the model grants them.
  logic [IW-1:0] exp_q[$];
  logic [AW-1:0] grant_log[$];
  logic [AW-1:0] order_ref[5];

  // Transaction-level model: at most one transaction open at a time.
  bit                    m_active, m_is_read, m_resp;
  int                    m_cons, m_last;
  logic [AW-1:0]         m_raddr, m_waddr;
  logic [DW-1:0]         m_wdata;
  logic [N-1:0][DW-1:0]  m_rdata;

  bit auto_release, mem_auto, rand_req;
  bit prev_mrv, prev_mwv, prev_rdy;
  bit c0_dropped, c0_again;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy();
    return (bus.consumer_read_valid != '0) || (bus.consumer_write_valid != '0) || m_active;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_resp = 0; m_last = N - 1;
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rdata = '0;
      exp_q.delete();
    end else if (!m_active) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (bus.consumer_read_valid[i] || bus.consumer_write_valid[i]) begin
          m_active = 1; m_resp = 0; m_cons = i; m_last = i;
          m_is_read = bus.consumer_read_valid[i];
          if (m_is_read) m_raddr = bus.consumer_read_address[i];
          else begin
            m_waddr = bus.consumer_write_address[i];
            m_wdata = bus.consumer_write_data[i];
          end
          exp_q.push_back(IW'(i));
          break;
        end
      end
    end else if (!m_resp) begin
      if (m_is_read && bus.mem_read_ready) begin
        m_resp = 1;
        m_rdata[m_cons] = bus.mem_read_data;
      end else if (!m_is_read && bus.mem_write_ready) begin
        m_resp = 1;
      end
    end else begin
      if (m_is_read ? !bus.consumer_read_valid[m_cons] : !bus.consumer_write_valid[m_cons])
        m_active = 0;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_rr, exp_wr;
    bit rdy_now;
    exp_rr = '0; exp_wr = '0;
    if (m_active && m_resp) begin
      if (m_is_read) exp_rr[m_cons] = 1'b1;
      else           exp_wr[m_cons] = 1'b1;
    end
    chk("mem_read_valid", bus.mem_read_valid, m_active && m_is_read && !m_resp);
    chk("mem_write_valid", bus.mem_write_valid, m_active && !m_is_read && !m_resp);
    chk("mem_read_address", bus.mem_read_address, m_raddr);
    chk("mem_write_address", bus.mem_write_address, m_waddr);
    chk("mem_write_data", bus.mem_write_data, m_wdata);
    chk("consumer_read_ready", bus.consumer_read_ready, exp_rr);
    chk("consumer_write_ready", bus.consumer_write_ready, exp_wr);
    chk("consumer_read_data", bus.consumer_read_data, m_rdata);
    chk("one_ready", $countones({bus.consumer_read_ready, bus.consumer_write_ready}) <= 1, 1);
    chk("one_mem_valid", bus.mem_read_valid && bus.mem_write_valid, 0);
    rdy_now = (bus.consumer_read_ready != '0) || (bus.consumer_write_ready != '0);
    if (rdy_now && !prev_rdy) begin
      logic [IW-1:0] got;
      got = '0;
      for (int i = 0; i < N; i++)
        if (bus.consumer_read_ready[i] || bus.consumer_write_ready[i]) got = IW'(i);
      if (exp_q.size() == 0) chk("grant_order_unexpected", got, 'x);
      else chk("grant_order", got, exp_q.pop_front());
    end
    if (bus.mem_read_valid && !prev_mrv) grant_log.push_back(bus.mem_read_address);
    if (bus.mem_write_valid && !prev_mwv) grant_log.push_back(bus.mem_write_address);
    prev_mrv = bus.mem_read_valid;
    prev_mwv = bus.mem_write_valid;
    prev_rdy = rdy_now;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int i = 0; i < N; i++) begin
      if (auto_release && bus.consumer_read_valid[i] && bus.consumer_read_ready[i])
        bus.consumer_read_valid[i] = 1'b0;
      if (auto_release && bus.consumer_write_valid[i] && bus.consumer_write_ready[i])
        bus.consumer_write_valid[i] = 1'b0;
      if (rand_req) begin
        bus.consumer_read_address[i]  = AW'($urandom);
        bus.consumer_write_address[i] = AW'($urandom);
        bus.consumer_write_data[i]    = DW'($urandom);
        if (!bus.consumer_read_valid[i] && !bus.consumer_read_ready[i] && $urandom_range(0, 5) == 0)
          bus.consumer_read_valid[i] = 1'b1;
        if (!bus.consumer_write_valid[i] && !bus.consumer_write_ready[i] && $urandom_range(0, 5) == 0)
          bus.consumer_write_valid[i] = 1'b1;
      end
    end
    if (mem_auto) begin
      bus.mem_read_ready  = ($urandom_range(0, 2) == 0);
      bus.mem_write_ready = ($urandom_range(0, 2) == 0);
      bus.mem_read_data   = DW'($urandom);
    end
  endtask

  task automatic run_until_quiet(int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      cycle();
      n++;
    end
    chk("quiet_timeout", busy(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.consumer_read_valid = '0;  bus.consumer_read_address = '0;
    bus.consumer_write_valid = '0; bus.consumer_write_address = '0;
    bus.consumer_write_data = '0;
    bus.mem_read_ready = 1'b0; bus.mem_read_data = '0; bus.mem_write_ready = 1'b0;
    auto_release = 0; mem_auto = 0; rand_req = 0;
    prev_mrv = 0; prev_mwv = 0; prev_rdy = 0;
    m_last = N - 1; m_cons = 0;

    cycle(); cycle();
    reset = 1'b0;
    chk("rst_mem_read_valid", bus.mem_read_valid, 0);
    chk("rst_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    chk("rst_state", bus.dbg_state, 0);

    // Single read: consumer 2, address 0x15, data 0xA7 two cycles after grant.
    bus.consumer_read_valid[2] = 1'b1; bus.consumer_read_address[2] = 8'h15;
    bus.mem_read_data = 8'hA7;
    cycle();
    chk("rd_grant_valid", bus.mem_read_valid, 1);
    chk("rd_grant_addr", bus.mem_read_address, 8'h15);
    cycle();
    bus.mem_read_ready = 1'b1;
    cycle();
    bus.mem_read_ready = 1'b0;
    chk("rd_data", bus.consumer_read_data[2], 8'hA7);
    chk("rd_ready", bus.consumer_read_ready, 4'b0100);
    cycle();
    chk("rd_ready_held", bus.consumer_read_ready, 4'b0100);
    bus.consumer_read_valid[2] = 1'b0;
    cycle();
    chk("rd_ready_clear", bus.consumer_read_ready, 4'b0000);

    // Single write: consumer 1 writes 0x3C to 0x40.
    bus.consumer_write_valid[1] = 1'b1; bus.consumer_write_address[1] = 8'h40;
    bus.consumer_write_data[1] = 8'h3C;
    cycle();
    chk("wr_addr", bus.mem_write_address, 8'h40);
    chk("wr_data", bus.mem_write_data, 8'h3C);
    bus.mem_write_ready = 1'b1;
    cycle();
    bus.mem_write_ready = 1'b0;
    chk("wr_ready", bus.consumer_write_ready, 4'b0010);
    bus.consumer_write_valid[1] = 1'b0;
    cycle();
    chk("wr_ready_clear", bus.consumer_write_ready, 4'b0000);
    chk("wr_mem_valid_low", bus.mem_write_valid, 0);

    // Contention after reset: 0,1,2,3 then consumer 0 again only after 3.
    do_reset();
    auto_release = 1; bus.mem_read_ready = 1'b1; bus.mem_write_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.consumer_read_valid[i] = 1'b1;
      bus.consumer_read_address[i] = AW'(8'h10 + i);
    end
    grant_log.delete();
    c0_dropped = 0; c0_again = 0;
    for (int n = 0; n < 80 && !(c0_again && !busy()); n++) begin
      cycle();
      if (c0_dropped && !c0_again) begin
        bus.consumer_read_valid[0] = 1'b1; bus.consumer_read_address[0] = 8'h20; c0_again = 1;
      end
      if (!c0_dropped && bus.consumer_read_ready[0]) c0_dropped = 1;
    end
    order_ref = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    chk("contention_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("contention_order", (i < grant_log.size()) ? grant_log[i] : 8'hxx, order_ref[i]);

    // Mixed: make consumer 2 the last grant, then consumer 3 writes while 0 reads.
    bus.consumer_read_valid[2] = 1'b1; bus.consumer_read_address[2] = 8'h22;
    run_until_quiet(40);
    grant_log.delete();
    bus.consumer_write_valid[3] = 1'b1; bus.consumer_write_address[3] = 8'h33;
    bus.consumer_write_data[3] = 8'h99;
    bus.consumer_read_valid[0] = 1'b1; bus.consumer_read_address[0] = 8'h01;
    run_until_quiet(40);
    chk("mixed_count", grant_log.size(), 2);
    chk("mixed_first", (grant_log.size() > 0) ? grant_log[0] : 8'hxx, 8'h33);
    chk("mixed_second", (grant_log.size() > 1) ? grant_log[1] : 8'hxx, 8'h01);

    // Slow memory: ready held low for 10 cycles while the LSU scribbles its address.
    bus.mem_read_ready = 1'b0; bus.mem_write_ready = 1'b0;
    bus.consumer_read_valid[1] = 1'b1; bus.consumer_read_address[1] = 8'h5A;
    cycle();
    for (int i = 0; i < 10; i++) begin
      bus.consumer_read_address[1] = AW'($urandom);
      cycle();
      chk("slow_valid", bus.mem_read_valid, 1);
      chk("slow_addr", bus.mem_read_address, 8'h5A);
      chk("slow_no_ready", bus.consumer_read_ready, 4'b0000);
    end
    bus.mem_read_ready = 1'b1;
    run_until_quiet(20);

    // Reset while consumer 3 waits on memory; consumer 1 also pending.
    bus.mem_read_ready = 1'b0;
    bus.consumer_read_valid[3] = 1'b1; bus.consumer_read_address[3] = 8'h77;
    bus.consumer_read_valid[1] = 1'b1; bus.consumer_read_address[1] = 8'h11;
    cycle();
    chk("midrst_grant_addr", bus.mem_read_address, 8'h77);
    chk("midrst_state_wait", bus.dbg_state, 1);
    do_reset();
    chk("midrst_valid", bus.mem_read_valid, 0);
    chk("midrst_ready", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    chk("midrst_state", bus.dbg_state, 0);
    cycle();
    chk("midrst_regrant", bus.mem_read_address, 8'h11);
    bus.mem_read_ready = 1'b1;
    run_until_quiet(40);

    // Randomized traffic including stray memory ready and occasional resets.
    mem_auto = 1; rand_req = 1;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;
    rand_req = 0;
    run_until_quiet(200);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
